inst_fetch_ctrl: RTL and testbench

//  Sequences the byte-addressed, combinational-read instruction memory: owns the PC, drives the fetch address,
//  and buffers fetched 16-bit instructions in a 2-entry queue toward decode with a valid/ready handshake.

---
 rtl/inst_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with 2-entry decode queue
//
// Owns the PC and drives it straight onto imem_addr. The instruction memory is
// read combinationally, so the word on imem_inst is captured in the same cycle.
// Fetched {pc, inst} pairs go into a 2-entry FIFO that feeds decode over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_en            1 = fetching allowed, 0 = pause
//   imem_addr/imem_inst fetch address (= pc) and combinational read data
//   redirect_valid/_pc  one-cycle redirect: flush queue, load new pc
//   out_valid/_ready    decode handshake; out_inst/out_pc show queue head
//   fault               sticky flag: illegal pc reached, fetching stopped
module inst_fetch_ctrl #(
  parameter int                 ADDR_W     = 16,
  parameter int                 IMEM_BYTES = 128,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // One extra bit so the limit compare is exact even when IMEM_BYTES == 2^ADDR_W.
  localparam logic [ADDR_W:0] IMEM_LIM = IMEM_BYTES[ADDR_W:0];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [1:0]        count_q, count_d;
  // Entry 0 is always the head; entry 1 only meaningful when count == 2.
  logic [ADDR_W-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [15:0]       e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;

  logic pop, push, pc_bad, redir_bad;

  function automatic logic illegal_pc(input logic [ADDR_W-1:0] a);
    return a[0] | ({1'b0, a} >= IMEM_LIM);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      fault_q   <= 1'b0;
      count_q   <= 2'd0;
      e0_pc_q   <= '0;
      e0_inst_q <= '0;
      e1_pc_q   <= '0;
      e1_inst_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    count_d   = count_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;
    push      = 1'b0;
    pop       = (count_q != 2'd0) & out_ready;
    pc_bad    = illegal_pc(pc_q);
    redir_bad = illegal_pc(redirect_pc);

    if (redirect_valid) begin
      // Flush only clears the count; entry 0 keeps its contents so the
      // outputs hold their last value while out_valid is low.
      count_d = 2'd0;
      pc_d    = redirect_pc;
      if (redir_bad) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        state_d = fetch_en ? S_FETCH : S_IDLE;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch_en) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (pc_bad) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            push = (count_q < 2'd2) | pop;
            if (push) pc_d = pc_q + ADDR_W'(2);
            if (!fetch_en) state_d = S_IDLE;
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase

      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d   = pc_q;
            e0_inst_d = imem_inst;
          end else begin
            e1_pc_d   = pc_q;
            e1_inst_d = imem_inst;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves entry 0 untouched (held output).
          if (count_q == 2'd2) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            e1_pc_d   = pc_q;
            e1_inst_d = imem_inst;
          end else begin
            e0_pc_d   = pc_q;
            e0_inst_d = imem_inst;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = e0_inst_q;
  assign out_pc    = e0_pc_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic        fault;

  inst_fetch_ctrl #(.ADDR_W(16), .IMEM_BYTES(128), .RESET_PC(16'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return (a < 16'd128) ? mem[a[6:1]] : 16'h0;
  endfunction

  assign imem_inst = mem_rd(imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch mode, pc, fault flag and the list of instructions
  // decode is still owed, in delivery order.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } ent_t;

  localparam int M_IDLE = 0, M_FETCH = 1, M_FAULT = 2;

  ent_t        exp_q[$];
  int          m_mode = M_IDLE;
  logic [15:0] m_pc = 16'h0;
  logic        m_fault = 1'b0;
  logic [15:0] last_pc = 16'h0;
  logic [15:0] last_inst = 16'h0;

  function automatic bit bad_pc(input logic [15:0] a);
    return (a % 2 != 0) || (a >= 16'd128);
  endfunction

  // Monitor + model: inputs settle 2 time units after each rising edge, so at
  // the falling edge the bench compares outputs, then predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = M_IDLE; m_pc = 16'h0; m_fault = 1'b0;
      last_pc = 16'h0; last_inst = 16'h0;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
    end else begin
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
      chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
      chk("fault", {31'h0, fault}, {31'h0, m_fault});
      if (exp_q.size() != 0) begin
        last_pc = exp_q[0].pc;
        last_inst = exp_q[0].inst;
      end
      if (out_valid) begin
        chk("head_pc", {16'h0, out_pc}, {16'h0, last_pc});
        chk("head_inst", {16'h0, out_inst}, {16'h0, last_inst});
      end else begin
        chk("hold_pc", {16'h0, out_pc}, {16'h0, last_pc});
        chk("hold_inst", {16'h0, out_inst}, {16'h0, last_inst});
      end
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc;
        if (bad_pc(redirect_pc)) begin
          m_mode = M_FAULT; m_fault = 1'b1;
        end else begin
          m_fault = 1'b0;
          m_mode = fetch_en ? M_FETCH : M_IDLE;
        end
      end else if (m_mode == M_IDLE) begin
        if (fetch_en) m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (bad_pc(m_pc)) begin
          m_mode = M_FAULT; m_fault = 1'b1;
        end else begin
          if (exp_q.size() < 2) begin
            exp_q.push_back('{pc: m_pc, inst: mem_rd(m_pc)});
            m_pc = m_pc + 16'd2;
          end
          if (!fetch_en) m_mode = M_IDLE;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic redirect(input logic [15:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_fault", {31'h0, fault}, 32'h0);
    chk("async_imem_addr", {16'h0, imem_addr}, 32'h0);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[0] = 16'h0A30; mem[1] = 16'h0413; mem[2] = 16'hFFC1;
    mem[3] = 16'h0113; mem[4] = 16'h0081; mem[5] = 16'h2023;

    cyc(3);
    rst_n = 1'b1;
    cyc();

    // 1: streaming, first instruction one cycle after the first FETCH cycle
    fetch_en = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t1_not_yet_valid", {31'h0, out_valid}, 32'h0);
    cyc();
    chk("t1_first_valid", {31'h0, out_valid}, 32'h1);
    chk("t1_first", {out_pc, out_inst}, 32'h0000_0A30);
    cyc();
    chk("t1_second", {out_pc, out_inst}, 32'h0002_0413);
    cyc();
    chk("t1_third", {out_pc, out_inst}, 32'h0004_FFC1);
    cyc(4);

    // 2: decode stalled, queue fills, pc parks at 4
    pulse_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    cyc(6);
    chk("t2_addr_parked", {16'h0, imem_addr}, 32'h4);
    chk("t2_head", {out_pc, out_inst}, 32'h0000_0A30);
    out_ready = 1'b1;
    cyc(6);

    // 3: redirect while full
    out_ready = 1'b0;
    redirect(16'h0);
    cyc(4);
    redirect(16'h8);
    chk("t3_flushed", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("t3_first", {out_pc, out_inst}, 32'h0008_0081);
    cyc();
    chk("t3_second", {out_pc, out_inst}, 32'h000A_2023);
    cyc(2);

    // 4: run off the end of memory
    redirect(16'h70);
    cyc(12);
    chk("t4_fault", {31'h0, fault}, 32'h1);
    chk("t4_drained", {31'h0, out_valid}, 32'h0);
    chk("t4_last", {out_pc, out_inst}, 32'h007E_0000);
    redirect(16'h0);
    chk("t4_fault_clear", {31'h0, fault}, 32'h0);
    cyc(3);

    // 5: odd redirect, then fetch_en toggles mid-stream
    redirect(16'h3);
    chk("t5_fault", {31'h0, fault}, 32'h1);
    chk("t5_empty", {31'h0, out_valid}, 32'h0);
    cyc(2);
    redirect(16'h0);
    cyc(3);
    fetch_en = 1'b0;
    cyc(3);
    fetch_en = 1'b1;
    cyc(5);

    // 6: reset while decode has a valid head
    chk("t6_busy", {31'h0, out_valid}, 32'h1);
    pulse_reset();
    cyc(4);

    // Randomized traffic
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      fetch_en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 7))
          0:       redirect_pc = 16'($urandom);
          1:       redirect_pc = 16'($urandom_range(0, 127)) | 16'h1;
          default: redirect_pc = 16'($urandom_range(0, 63)) << 1;
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) begin
        redirect_valid = 1'b0;
        pulse_reset();
      end else begin
        cyc();
      end
    end
    redirect_valid = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
